// File: rtl/ifu.sv
// Instruction fetch unit: PC sequencing, combinational instruction memory read, program load and fault capture.
// Zero-latency fetch; PC/count update on each RUN edge. No backpressure: prog_en stalls fetch, FAULT holds until reload or reset.
module ifu #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  nPc_Sel,
    input  logic        Branch_Jump,
    input  logic        Zero,
    input  logic [31:0] RegRs,
    input  logic        prog_en,
    input  logic        prog_we,
    input  logic [9:0]  prog_addr,
    input  logic [31:0] prog_data,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [5:0]  Function,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        fault,
    output logic [31:0] instr_count
);

    localparam int          AW       = $clog2(IM_WORDS);
    localparam logic [31:0] IM_BYTES = 32'(4 * IM_WORDS);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] im [IM_WORDS];
    logic [31:0] pc_off;
    logic        fetch_ok;
    logic        pc_adv;
    logic        load_exit;
    logic        fault_set;
    logic        im_wr;
    logic [31:0] pc_next;
    logic [31:0] br_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Offset relative to the window base; wraparound makes below-window PCs look huge.
    assign pc_off   = PC - PC_RESET;
    assign fetch_ok = (pc_off < IM_BYTES) && (PC[1:0] == 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (prog_en) begin
                    state_nxt = LOAD;
                end else if (!fetch_ok) begin
                    state_nxt = FAULT;
                end
            end
            LOAD:    state_nxt = prog_en ? LOAD : RUN;
            FAULT:   state_nxt = prog_en ? LOAD : FAULT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        Instr     = 32'h0000_0000;
        pc_adv    = 1'b0;
        load_exit = 1'b0;
        fault_set = 1'b0;
        im_wr     = 1'b0;
        if (state == RUN && fetch_ok) begin
            Instr = im[pc_off[AW+1:2]];
        end
        case (state)
            RUN: begin
                pc_adv    = !prog_en && fetch_ok;
                fault_set = !prog_en && !fetch_ok;
            end
            LOAD: begin
                load_exit = !prog_en;
                im_wr     = prog_we && (32'(prog_addr) < IM_WORDS);
            end
            default: ;
        endcase
    end

    assign Op       = Instr[31:26];
    assign Function = Instr[5:0];
    assign PC4      = PC + 32'd4;
    assign br_off   = {{14{Instr[15]}}, Instr[15:0], 2'b00};

    always_comb begin
        pc_next = PC4;
        case (nPc_Sel)
            2'd0:    pc_next = (Branch_Jump && Zero) ? PC4 + br_off : PC4;
            2'd1:    pc_next = {PC4[31:28], Instr[25:0], 2'b00};
            2'd2:    pc_next = RegRs;
            default: pc_next = PC4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC          <= PC_RESET;
            instr_count <= 32'd0;
            fault       <= 1'b0;
        end else begin
            if (pc_adv) begin
                PC          <= pc_next;
                instr_count <= instr_count + 32'd1;
            end
            if (load_exit) begin
                PC          <= PC_RESET;
                instr_count <= 32'd0;
                fault       <= 1'b0;
            end
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

    // Memory has no reset so a reset during LOAD keeps the words already written.
    always_ff @(posedge clk) begin
        if (!reset && im_wr) begin
            im[prog_addr[AW-1:0]] <= prog_data;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: load, sequential fetch, branch/jal/jr, fault entry and exit, reset during load.
module tb_ifu;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  nPc_Sel;
    logic        Branch_Jump;
    logic        Zero;
    logic [31:0] RegRs;
    logic        prog_en;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] Instr;
    logic [5:0]  Op;
    logic [5:0]  Function;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        fault;
    logic [31:0] instr_count;

    int checks = 0;
    int passed = 0;

    ifu dut (
        .clk         (clk),
        .reset       (reset),
        .nPc_Sel     (nPc_Sel),
        .Branch_Jump (Branch_Jump),
        .Zero        (Zero),
        .RegRs       (RegRs),
        .prog_en     (prog_en),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .Instr       (Instr),
        .Op          (Op),
        .Function    (Function),
        .PC          (PC),
        .PC4         (PC4),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic reload();
        prog_en = 1'b1;
        tick();
        prog_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (PC !== 32'h3000) $display("FAIL reset_pc got %h want 3000", PC); else passed++;
        checks++; if (PC4 !== 32'h3004) $display("FAIL reset_pc4 got %h want 3004", PC4); else passed++;
        checks++; if (instr_count !== 32'd0) $display("FAIL reset_count got %0d want 0", instr_count); else passed++;
        checks++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else passed++;
    endtask

    task automatic test_sequential();
        prog_en = 1'b1;
        tick();
        checks++; if (Instr !== 32'h0) $display("FAIL load_instr_zero got %h want 0", Instr); else passed++;
        load_word(10'd0, 32'h3401_0005);
        // final write on the same edge prog_en drops
        prog_we = 1'b1; prog_addr = 10'd1; prog_data = 32'h3c02_ffff; prog_en = 1'b0;
        tick();
        prog_we = 1'b0;
        #1;
        checks++; if (PC !== 32'h3000) $display("FAIL seq_pc0 got %h want 3000", PC); else passed++;
        checks++; if (Instr !== 32'h3401_0005) $display("FAIL seq_instr0 got %h want 34010005", Instr); else passed++;
        checks++; if (Op !== 6'h0d || Function !== 6'h05) $display("FAIL seq_fields got %h/%h want 0d/05", Op, Function); else passed++;
        tick();
        checks++; if (PC !== 32'h3004) $display("FAIL seq_pc1 got %h want 3004", PC); else passed++;
        checks++; if (Instr !== 32'h3c02_ffff) $display("FAIL seq_instr1 got %h want 3c02ffff", Instr); else passed++;
        tick();
        checks++; if (PC !== 32'h3008) $display("FAIL seq_pc2 got %h want 3008", PC); else passed++;
        checks++; if (instr_count !== 32'd2) $display("FAIL seq_count got %0d want 2", instr_count); else passed++;
    endtask

    task automatic test_branch();
        prog_en = 1'b1;
        tick();
        load_word(10'd0, 32'h1000_0002);
        load_word(10'd1, 32'h1000_fffe);
        prog_en = 1'b0;
        tick();
        nPc_Sel = 2'd0; Branch_Jump = 1'b1; Zero = 1'b1;
        tick();
        Branch_Jump = 1'b0; Zero = 1'b0;
        checks++; if (PC !== 32'h300c) $display("FAIL beq_taken got %h want 300c", PC); else passed++;
        reload();
        Branch_Jump = 1'b1; Zero = 1'b0;
        tick();
        checks++; if (PC !== 32'h3004) $display("FAIL beq_not_taken got %h want 3004", PC); else passed++;
        Zero = 1'b1;
        tick();
        checks++; if (PC !== 32'h3000) $display("FAIL beq_backward got %h want 3000", PC); else passed++;
        checks++; if (instr_count !== 32'd2) $display("FAIL beq_count got %0d want 2", instr_count); else passed++;
        Branch_Jump = 1'b0;
        tick();
        checks++; if (PC !== 32'h3004) $display("FAIL zero_no_bj got %h want 3004", PC); else passed++;
        Zero = 1'b0;
    endtask

    task automatic test_jal_jr();
        prog_en = 1'b1;
        tick();
        load_word(10'd0, 32'h0c00_0c10);
        prog_en = 1'b0;
        tick();
        nPc_Sel = 2'd1;
        #1;
        checks++; if (PC4 !== 32'h3004) $display("FAIL jal_pc4 got %h want 3004", PC4); else passed++;
        checks++; if (Op !== 6'h03) $display("FAIL jal_op got %h want 03", Op); else passed++;
        tick();
        checks++; if (PC !== 32'h3040) $display("FAIL jal_target got %h want 3040", PC); else passed++;
        nPc_Sel = 2'd2; RegRs = 32'h3004;
        tick();
        checks++; if (PC !== 32'h3004) $display("FAIL jr_target got %h want 3004", PC); else passed++;
        nPc_Sel = 2'd3;
        tick();
        checks++; if (PC !== 32'h3008) $display("FAIL sel3_seq got %h want 3008", PC); else passed++;
        checks++; if (instr_count !== 32'd3) $display("FAIL jal_count got %0d want 3", instr_count); else passed++;
        nPc_Sel = 2'd0;
    endtask

    task automatic test_fault();
        nPc_Sel = 2'd2; RegRs = 32'h2ffc;
        tick();
        nPc_Sel = 2'd0;
        #1;
        checks++; if (PC !== 32'h2ffc || Instr !== 32'h0) $display("FAIL below_window pc/instr got %h/%h want 2ffc/0", PC, Instr); else passed++;
        checks++; if (fault !== 1'b0) $display("FAIL fault_early got %b want 0", fault); else passed++;
        tick();
        checks++; if (fault !== 1'b1) $display("FAIL fault_set got %b want 1", fault); else passed++;
        tick();
        checks++; if (PC !== 32'h2ffc || instr_count !== 32'd4) $display("FAIL fault_hold pc/count got %h/%0d want 2ffc/4", PC, instr_count); else passed++;
        checks++; if (Instr !== 32'h0 || fault !== 1'b1) $display("FAIL fault_instr got %h/%b want 0/1", Instr, fault); else passed++;
        reload();
        checks++; if (PC !== 32'h3000 || fault !== 1'b0 || instr_count !== 32'd0) $display("FAIL fault_exit got %h/%b/%0d want 3000/0/0", PC, fault, instr_count); else passed++;
        nPc_Sel = 2'd2; RegRs = 32'h3002;
        tick();
        nPc_Sel = 2'd0;
        tick();
        checks++; if (fault !== 1'b1 || PC !== 32'h3002) $display("FAIL misaligned got %b/%h want 1/3002", fault, PC); else passed++;
        reload();
        nPc_Sel = 2'd2; RegRs = 32'h3ffc;
        tick();
        nPc_Sel = 2'd0;
        checks++; if (fault !== 1'b0 || instr_count !== 32'd1) $display("FAIL last_word got %b/%0d want 0/1", fault, instr_count); else passed++;
        tick();
        checks++; if (PC !== 32'h4000 || instr_count !== 32'd2) $display("FAIL top_edge got %h/%0d want 4000/2", PC, instr_count); else passed++;
        tick();
        checks++; if (fault !== 1'b1 || PC !== 32'h4000 || instr_count !== 32'd2) $display("FAIL above_window got %b/%h/%0d want 1/4000/2", fault, PC, instr_count); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (fault !== 1'b0 || PC !== 32'h3000) $display("FAIL reset_exit got %b/%h want 0/3000", fault, PC); else passed++;
    endtask

    task automatic test_reset_mid_load();
        prog_en = 1'b1;
        tick();
        load_word(10'd5, 32'hdead_beef);
        // reset outranks a write on the same edge
        reset = 1'b1; prog_we = 1'b1; prog_addr = 10'd5; prog_data = 32'h1111_1111;
        tick();
        reset = 1'b0; prog_we = 1'b0; prog_en = 1'b0;
        #1;
        checks++; if (PC !== 32'h3000 || instr_count !== 32'd0) $display("FAIL rst_load pc/count got %h/%0d want 3000/0", PC, instr_count); else passed++;
        checks++; if (Instr !== 32'h0c00_0c10) $display("FAIL rst_load_run got %h want 0c000c10", Instr); else passed++;
        nPc_Sel = 2'd2; RegRs = 32'h3014;
        tick();
        checks++; if (Instr !== 32'hdead_beef) $display("FAIL rst_load_keep got %h want deadbeef", Instr); else passed++;
    endtask

    task automatic test_we_in_run();
        nPc_Sel = 2'd2; RegRs = 32'h3000;
        tick();
        prog_we = 1'b1; prog_addr = 10'd0; prog_data = 32'hffff_ffff;
        tick();
        tick();
        prog_we = 1'b0;
        #1;
        checks++; if (PC !== 32'h3000 || Instr !== 32'h0c00_0c10) $display("FAIL we_in_run got %h/%h want 3000/0c000c10", PC, Instr); else passed++;
        nPc_Sel = 2'd0;
    endtask

    initial begin
        reset = 1'b0; nPc_Sel = 2'd0; Branch_Jump = 1'b0; Zero = 1'b0; RegRs = 32'h0;
        prog_en = 1'b0; prog_we = 1'b0; prog_addr = 10'd0; prog_data = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jal_jr();
        test_fault();
        test_reset_mid_load();
        test_we_in_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL use parameter PC_RESET, default 32'h0000_3000, as the PC value after reset and after program load.
REQ-002 The block SHALL use parameter IM_WORDS, default 1024, as the instruction memory depth in 32-bit words; the valid PC window is [PC_RESET, PC_RESET + 4*IM_WORDS).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 nPc_Sel  in  2  next-PC source: 0 sequential/branch, 1 jal target, 2 jr register, 3 reserved.
REQ-006 Branch_Jump  in  1  current instruction is a control transfer.
REQ-007 Zero  in  1  ALU equality result for beq.
REQ-008 RegRs  in  32  rs register value, the jr target.
REQ-009 prog_en  in  1  program-load mode request.
REQ-010 prog_we  in  1  instruction memory write strobe, honoured only in LOAD.
REQ-011 prog_addr  in  10  instruction memory word index.
REQ-012 prog_data  in  32  instruction word to write.
REQ-013 Instr  out  32  current instruction word.
REQ-014 Op  out  6  Instr[31:26].
REQ-015 Function  out  6  Instr[5:0].
REQ-016 PC  out  32  current program counter.
REQ-017 PC4  out  32  PC + 4, the jal link value.
REQ-018 fault  out  1  sticky out-of-window or misaligned fetch flag.
REQ-019 instr_count  out  32  count of instructions retired since reset or load.

Function
REQ-020 The block SHALL implement the states RUN, LOAD and FAULT; the reset state SHALL be RUN.
REQ-021 Instruction memory read SHALL be combinational: Instr = IM[PC[11:2] - PC_RESET[11:2]] while in RUN with PC inside the window and PC[1:0] = 0.
REQ-022 Instr SHALL be 32'h0000_0000 (sll nop) in LOAD, in FAULT, and for any out-of-window PC.
REQ-023 In RUN with nPc_Sel = 0 and (Branch_Jump & Zero) = 1 (beq taken), next PC SHALL be PC + 4 + (sign_extend(Instr[15:0]) << 2).
REQ-024 In RUN with nPc_Sel = 0 and the branch not taken, next PC SHALL be PC + 4.
REQ-025 In RUN with nPc_Sel = 1, next PC SHALL be {PC4[31:28], Instr[25:0], 2'b00}.
REQ-026 In RUN with nPc_Sel = 2, next PC SHALL be RegRs.
REQ-027 In RUN with nPc_Sel = 3, next PC SHALL be PC + 4.
REQ-028 Address arithmetic SHALL be modulo 2^32, with no overflow detection.
REQ-029 Each RUN cycle with the current PC valid SHALL update PC to next PC and increment instr_count by 1; instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 When the current PC is out of window or misaligned in RUN, the next edge SHALL enter FAULT, set fault = 1, hold PC, and leave instr_count unchanged.
REQ-031 FAULT SHALL hold PC and instr_count, and be exited only by reset or prog_en = 1.
REQ-032 prog_en = 1 in RUN or FAULT SHALL enter LOAD on the next edge; PC and instr_count SHALL hold on that edge.
REQ-033 In LOAD, prog_we = 1 SHALL write prog_data to IM[prog_addr] at the edge, and that word SHALL become readable on the next fetch.
REQ-034 prog_we SHALL be ignored outside LOAD; prog_addr values >= IM_WORDS SHALL be ignored.
REQ-035 prog_en = 0 in LOAD SHALL return to RUN on the next edge with PC = PC_RESET, instr_count = 0 and fault = 0.
REQ-036 If prog_en falls on the same edge that carries a final write, the write SHALL complete before RUN resumes.

Reset
REQ-037 reset = 1 at an edge SHALL force state = RUN, PC = PC_RESET, instr_count = 0 and fault = 0.
REQ-038 reset SHALL take priority over prog_en, prog_we and every next-PC source.
REQ-039 Instruction memory contents SHALL NOT be altered by reset.
REQ-040 A reset asserted during LOAD SHALL abort the load; words already written SHALL be retained.

Verification
REQ-041 The bench SHALL cover this case: load IM[0] = 34010005 (ori) and IM[1] = 3c02ffff (lui) -> after release PC = 3000, then 3004, then 3008; instr_count = 2 after two edges.
REQ-042 The bench SHALL cover this case: IM[0] = 10000002 (beq), Branch_Jump = 1, Zero = 1 -> next PC = 300c; with Zero = 0 -> next PC = 3004.
REQ-043 The bench SHALL cover this case: IM[0] = 0c000c10 (jal), nPc_Sel = 1 -> PC4 = 3004, next PC = 3040; then nPc_Sel = 2 with RegRs = 3004 -> next PC = 3004.
REQ-044 The bench SHALL cover this case: jr with RegRs = 2ffc -> one edge later fault = 1, Instr = 0, and PC and instr_count frozen; asserting then releasing prog_en -> PC = 3000, fault = 0.
REQ-045 The bench SHALL cover this case: reset asserted mid-LOAD after writing IM[5] -> state RUN, PC = 3000, and IM[5] still holds the written value.
REQ-046 The bench SHALL cover this case: prog_we = 1 while in RUN -> IM unchanged.
